eth_rx_classifier: RTL and testbench
====================================

// Module: eth_rx_classifier
// PURPOSE
//  Receive-side header decoder for the 32-bit Ethernet word stream (sop/eop/vld/rdy) that feeds packet_sender.
//  Parses words 0..10 of each frame and classifies it as ARP request, ICMP echo request or UDP to self.
//  Presents the reply fields (peer MAC/IP, ICMP id/seq, UDP ports) as one held result with a vld/ack handshake.
//  Sits between the MAC rx FIFO and the reply/transmit logic.
// PARAMETERS
//  UDP_PORT   16'h5152  UDP destination port accepted as ours
// PORTS
//  clk            in   1   single clock; all logic on posedge
//  rst_n          in   1   reset, synchronous, active-low
//  i_self_mac     in   48  own MAC; quasi-static
//  i_self_ip      in   32  own IPv4 address; quasi-static
//  i_rx_data      in   32  frame word; word0={16'h0,dst_mac[47:32]}, word1=dst_mac[31:0], word2=src_mac[47:16], word3={src_mac[15:0],ethertype}
//  i_rx_sop       in   1   first word of frame
//  i_rx_eop       in   1   last word of frame
//  i_rx_vld       in   1   word valid; a beat is accepted when i_rx_vld & o_rx_rdy
//  o_rx_rdy       out  1   = ~o_pkt_vld (stall the stream while a result is pending)
//  o_pkt_vld      out  1   classified result available
//  i_pkt_ack      in   1   consumer takes the result
//  o_pkt_type     out  2   0 NONE, 1 ARP_REQ, 2 ICMP_ECHO, 3 UDP
//  o_peer_mac     out  48  src MAC (Ethernet); for ARP, sha
//  o_peer_ip      out  32  IP src_ip; for ARP, spa
//  o_icmp_id      out  16  ICMP identifier (ICMP only; otherwise 0)
//  o_icmp_seq     out  16  ICMP sequence number (ICMP only; otherwise 0)
//  o_udp_src_port out  16  UDP source port (UDP only; otherwise 0)
//  o_drop_cnt     out  16  malformed-frame counter; wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset: every output 0 except o_rx_rdy=1; FSM=IDLE; word counter=0.
//  FSM: IDLE --sop beat--> HDR (word counter counts words 0..10); HDR --word10--> SKIP until eop; eop beat --> IDLE.
//   If eop arrives at word 10 itself, the FSM returns straight to IDLE.
//  IDLE: beats without sop are ignored and o_rx_rdy stays 1.
//  Beat fields by word:
//   ARP (ethertype 0806): w4 must be 00010800; w5[15:0]=opcode; w6/w7=sha; w7/w8=spa; w10=tpa.
//   IPv4 (0800): w4[31:24] must be 45; w6[23:16]=proto; w7=src_ip; w8=dst_ip.
//    ICMP: w9[31:16] must be 0800 (type 08, code 00); w10={id,seq}.
//    UDP: w9={src_port,dst_port}.
//  Match rules (all evaluated at the eop beat):
//   dst_mac is 48'hFFFFFFFFFFFF or i_self_mac;
//   ARP_REQ: opcode=0001 and tpa=i_self_ip;
//   ICMP_ECHO: proto=01 and dst_ip=i_self_ip;
//   UDP: proto=11 and dst_ip=i_self_ip and dst_port=UDP_PORT.
//  Result: on an accepted eop beat of a matching frame, o_pkt_vld=1 in the next cycle (latency 1) with all fields valid.
//   Fields are held stable until i_pkt_ack is seen with o_pkt_vld=1; o_pkt_vld falls in the following cycle.
//  Non-matching well-formed frames produce no result and no count.
//  Malformed (o_drop_cnt+1, no result):
//   eop before word 10 (runt);
//   sop in HDR/SKIP, which aborts the current frame and restarts at word0 with the new beat.
//   Simultaneous sop+eop on one beat is a runt.
//  Field capture uses shadow registers; the output registers update only at the eop commit, so a pending result is never corrupted.
//  i_rx_vld=0 mid-frame: the FSM and word counter hold.
//  The word counter saturates at 11.
//  rst_n low mid-frame or mid-result: return to reset state; any partial frame is discarded uncounted.
// STRUCTURE
//  Shared package eth_pkg:
//   ETH_TYPE_ARP=16'h0806, ETH_TYPE_IPV4=16'h0800;
//   IP_PROTO_ICMP=8'h01, IP_PROTO_UDP=8'h11;
//   ARP_OP_REQ=16'h0001;
//   pkt_type codes PKT_NONE/ARP_REQ/ICMP_ECHO/UDP;
//   header word indices W_DST0..W_W10.
//  Single module; no sub-module needed. The packet_sender reply path is expected to import the same package.
// TESTING (i_self_mac=002236EC0401, i_self_ip=0A000014)
//  ARP broadcast, sha=3CF011B2523C, spa=C0A8012E, tpa=0A000014
//   -> type 1, o_peer_mac=3CF011B2523C, o_peer_ip=C0A8012E, vld 1 cycle after eop.
//  Ping: src_mac 0C54A5312485, src_ip 0A000016, w9=080082AF, w10=148645C1, 25 words
//   -> type 2, icmp_id=1486, icmp_seq=45C1; words 11..24 accepted with rdy=1.
//  UDP: w9=11225152
//   -> type 3, o_udp_src_port=1122.
//   Same frame with w9=11225153, or with dst_ip=0A000015 -> no o_pkt_vld, o_drop_cnt unchanged.
//  Runt: ARP frame with eop on word 5 -> no result, o_drop_cnt=1.
//   New sop at word 7 of a ping, then a full ARP -> o_drop_cnt=2, ARP result correct.
//  Backpressure: hold i_pkt_ack=0 for 20 cycles after a ping result
//   -> o_rx_rdy=0, next ARP frame stalled, fields unchanged.
//   Ack -> next cycle o_pkt_vld=0, o_rx_rdy=1, ARP result 1 cycle after its eop.
//  rst_n low at word 6 -> all outputs 0, o_rx_rdy=1; next full frame classified normally.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4 constants and types for the receive classifier and the reply path.
package eth_pkg;

    localparam logic [15:0] ETH_TYPE_ARP      = 16'h0806;
    localparam logic [15:0] ETH_TYPE_IPV4     = 16'h0800;
    localparam logic [7:0]  IP_PROTO_ICMP     = 8'h01;
    localparam logic [7:0]  IP_PROTO_UDP      = 8'h11;
    localparam logic [15:0] ARP_OP_REQ        = 16'h0001;
    localparam logic [31:0] ARP_HW_PROTO_IPV4 = 32'h00010800;
    localparam logic [7:0]  IPV4_VER_IHL      = 8'h45;
    localparam logic [15:0] ICMP_ECHO_REQ     = 16'h0800;
    localparam logic [47:0] MAC_BCAST         = 48'hFFFF_FFFF_FFFF;

    // Header word indices as they appear on the 32-bit rx stream
    localparam int W_DST0 = 0;
    localparam int W_DST1 = 1;
    localparam int W_SRC0 = 2;
    localparam int W_SRC1 = 3;
    localparam int W_W4   = 4;
    localparam int W_W5   = 5;
    localparam int W_W6   = 6;
    localparam int W_W7   = 7;
    localparam int W_W8   = 8;
    localparam int W_W9   = 9;
    localparam int W_W10  = 10;
    localparam int HDR_WORDS = 11;

    localparam logic [3:0] LAST_HDR = 4'd10;
    localparam logic [3:0] CNT_SAT  = 4'd11;

    typedef enum logic [1:0] {
        PKT_NONE      = 2'd0,
        PKT_ARP_REQ   = 2'd1,
        PKT_ICMP_ECHO = 2'd2,
        PKT_UDP       = 2'd3
    } pkt_type_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_HDR  = 2'd1,
        RX_SKIP = 2'd2
    } rx_state_e;

    typedef struct packed {
        pkt_type_e   pkt_type;
        logic [47:0] peer_mac;
        logic [31:0] peer_ip;
        logic [15:0] icmp_id;
        logic [15:0] icmp_seq;
        logic [15:0] udp_src_port;
    } pkt_result_t;

endpackage

// File: rtl/eth_rx_classifier.sv
// Receive header decoder: captures words 0..10 of each frame and classifies it as
// ARP request, ICMP echo request or UDP-to-self, holding the result until acked.
module eth_rx_classifier
    import eth_pkg::*;
#(
    parameter logic [15:0] UDP_PORT = 16'h5152
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_sop,
    input  logic        i_rx_eop,
    input  logic        i_rx_vld,
    output logic        o_rx_rdy,
    output logic        o_pkt_vld,
    input  logic        i_pkt_ack,
    output logic [1:0]  o_pkt_type,
    output logic [47:0] o_peer_mac,
    output logic [31:0] o_peer_ip,
    output logic [15:0] o_icmp_id,
    output logic [15:0] o_icmp_seq,
    output logic [15:0] o_udp_src_port,
    output logic [15:0] o_drop_cnt
);

    rx_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hdr_q [HDR_WORDS];
    logic [31:0] hdr_d [HDR_WORDS];
    pkt_result_t res_q, res_d, cls;
    logic        pkt_vld_q, pkt_vld_d;
    logic [15:0] drop_q, drop_d;

    logic        beat, start, abort, hdr_beat, runt, commit;
    logic [47:0] dst_mac;
    logic [15:0] eth_type;
    logic        mac_ok, is_arp_req, is_ipv4_self, is_icmp_echo, is_udp_self;

    // The stream is stalled for as long as a result waits for its consumer
    assign beat     = i_rx_vld & ~pkt_vld_q;
    assign o_rx_rdy = ~pkt_vld_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = i_rx_eop ? RX_IDLE : RX_HDR;
            cnt_d   = i_rx_eop ? 4'd0 : 4'd1;
        end else if (beat && (state_q != RX_IDLE)) begin
            if (i_rx_eop) begin
                state_d = RX_IDLE;
                cnt_d   = 4'd0;
            end else if ((state_q == RX_HDR) && (cnt_q == LAST_HDR)) begin
                state_d = RX_SKIP;
                cnt_d   = CNT_SAT;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // A sop always restarts at word 0; seen outside IDLE it also aborts the frame in flight
    always_comb begin
        start    = beat & i_rx_sop;
        abort    = start & (state_q != RX_IDLE);
        hdr_beat = beat & ~i_rx_sop & (state_q == RX_HDR);
        runt     = beat & i_rx_eop & (start | (hdr_beat & (cnt_q < LAST_HDR)));
        commit   = beat & i_rx_eop & ~i_rx_sop &
                   (((state_q == RX_HDR) && (cnt_q == LAST_HDR)) || (state_q == RX_SKIP));
    end

    always_comb begin
        hdr_d = hdr_q;
        if (start) begin
            hdr_d[W_DST0] = i_rx_data;
        end else if (hdr_beat) begin
            hdr_d[cnt_q] = i_rx_data;
        end
    end

    assign dst_mac      = {hdr_d[W_DST0][15:0], hdr_d[W_DST1]};
    assign eth_type     = hdr_d[W_SRC1][15:0];
    assign mac_ok       = (dst_mac == MAC_BCAST) || (dst_mac == i_self_mac);
    assign is_arp_req   = (eth_type == ETH_TYPE_ARP) && (hdr_d[W_W4] == ARP_HW_PROTO_IPV4) &&
                          (hdr_d[W_W5][15:0] == ARP_OP_REQ) && (hdr_d[W_W10] == i_self_ip);
    assign is_ipv4_self = (eth_type == ETH_TYPE_IPV4) && (hdr_d[W_W4][31:24] == IPV4_VER_IHL) &&
                          (hdr_d[W_W8] == i_self_ip);
    assign is_icmp_echo = is_ipv4_self && (hdr_d[W_W6][23:16] == IP_PROTO_ICMP) &&
                          (hdr_d[W_W9][31:16] == ICMP_ECHO_REQ);
    assign is_udp_self  = is_ipv4_self && (hdr_d[W_W6][23:16] == IP_PROTO_UDP) &&
                          (hdr_d[W_W9][15:0] == UDP_PORT);

    // Classification looks at hdr_d so an eop landing on word 10 sees that word too
    always_comb begin
        cls = '0;
        if (mac_ok && is_arp_req) begin
            cls.pkt_type = PKT_ARP_REQ;
            cls.peer_mac = {hdr_d[W_W6], hdr_d[W_W7][31:16]};
            cls.peer_ip  = {hdr_d[W_W7][15:0], hdr_d[W_W8][31:16]};
        end else if (mac_ok && is_icmp_echo) begin
            cls.pkt_type = PKT_ICMP_ECHO;
            cls.peer_mac = {hdr_d[W_SRC0], hdr_d[W_SRC1][31:16]};
            cls.peer_ip  = hdr_d[W_W7];
            cls.icmp_id  = hdr_d[W_W10][31:16];
            cls.icmp_seq = hdr_d[W_W10][15:0];
        end else if (mac_ok && is_udp_self) begin
            cls.pkt_type     = PKT_UDP;
            cls.peer_mac     = {hdr_d[W_SRC0], hdr_d[W_SRC1][31:16]};
            cls.peer_ip      = hdr_d[W_W7];
            cls.udp_src_port = hdr_d[W_W9][31:16];
        end
    end

    always_comb begin
        res_d     = res_q;
        pkt_vld_d = pkt_vld_q;
        if (commit && (cls.pkt_type != PKT_NONE)) begin
            res_d     = cls;
            pkt_vld_d = 1'b1;
        end else if (pkt_vld_q && i_pkt_ack) begin
            pkt_vld_d = 1'b0;
        end
    end

    assign drop_d = drop_q + {15'd0, abort} + {15'd0, runt};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            hdr_q     <= '{default: '0};
            res_q     <= '0;
            pkt_vld_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            res_q     <= res_d;
            pkt_vld_q <= pkt_vld_d;
            drop_q    <= drop_d;
        end
    end

    assign o_pkt_vld      = pkt_vld_q;
    assign o_pkt_type     = res_q.pkt_type;
    assign o_peer_mac     = res_q.peer_mac;
    assign o_peer_ip      = res_q.peer_ip;
    assign o_icmp_id      = res_q.icmp_id;
    assign o_icmp_seq     = res_q.icmp_seq;
    assign o_udp_src_port = res_q.udp_src_port;
    assign o_drop_cnt     = drop_q;

endmodule

// File: tb/tb_eth_rx_classifier.sv
// Self-checking bench for eth_rx_classifier: directed scenarios plus randomized frames
// checked against a byte-level protocol model.
module tb_eth_rx_classifier;

    localparam logic [47:0] SELF_MAC = 48'h002236EC0401;
    localparam logic [31:0] SELF_IP  = 32'h0A000014;
    localparam logic [47:0] BCAST    = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] self_mac;
    logic [31:0] self_ip;
    logic [31:0] rx_data;
    logic        rx_sop, rx_eop, rx_vld, pkt_ack;
    logic        o_rx_rdy, o_pkt_vld;
    logic [1:0]  o_pkt_type;
    logic [47:0] o_peer_mac;
    logic [31:0] o_peer_ip;
    logic [15:0] o_icmp_id, o_icmp_seq, o_udp_src_port, o_drop_cnt;

    always #5 clk = ~clk;

    eth_rx_classifier #(.UDP_PORT(16'h5152)) dut (
        .clk(clk), .rst_n(rst_n), .i_self_mac(self_mac), .i_self_ip(self_ip),
        .i_rx_data(rx_data), .i_rx_sop(rx_sop), .i_rx_eop(rx_eop), .i_rx_vld(rx_vld),
        .o_rx_rdy(o_rx_rdy), .o_pkt_vld(o_pkt_vld), .i_pkt_ack(pkt_ack),
        .o_pkt_type(o_pkt_type), .o_peer_mac(o_peer_mac), .o_peer_ip(o_peer_ip),
        .o_icmp_id(o_icmp_id), .o_icmp_seq(o_icmp_seq), .o_udp_src_port(o_udp_src_port),
        .o_drop_cnt(o_drop_cnt)
    );

    wire [129:0] obs = {o_pkt_type, o_peer_mac, o_peer_ip, o_icmp_id, o_icmp_seq, o_udp_src_port};

    int compared = 0;
    int mismatched = 0;
    logic [31:0] frame [$];
    logic [7:0]  hb [42];

    task automatic build_eth(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
        frame = {};
        frame.push_back({16'h0000, dst[47:32]});
        frame.push_back(dst[31:0]);
        frame.push_back(src[47:16]);
        frame.push_back({src[15:0], et});
    endtask

    task automatic build_arp(input logic [47:0] dst, input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input logic [15:0] op);
        build_eth(dst, sha, 16'h0806);
        frame.push_back(32'h00010800);
        frame.push_back({16'h0604, op});
        frame.push_back(sha[47:16]);
        frame.push_back({sha[15:0], spa[31:16]});
        frame.push_back({spa[15:0], 16'h0000});
        frame.push_back(32'h0000_0000);
        frame.push_back(tpa);
        while (frame.size() < 15) frame.push_back($urandom);
    endtask

    task automatic build_ip(input logic [47:0] dst, input logic [47:0] smac, input logic [31:0] sip,
                            input logic [31:0] dip, input logic [7:0] proto, input logic [31:0] w9,
                            input logic [31:0] w10, input int nwords);
        build_eth(dst, smac, 16'h0800);
        frame.push_back(32'h4500_0054);
        frame.push_back(32'h1234_4000);
        frame.push_back({8'h40, proto, 16'hBEEF});
        frame.push_back(sip);
        frame.push_back(dip);
        frame.push_back(w9);
        frame.push_back(w10);
        while (frame.size() < nwords) frame.push_back($urandom);
    endtask

    function automatic logic [47:0] be(input int start, input int n);
        logic [47:0] v = '0;
        for (int k = 0; k < n; k++) v = {v[39:0], hb[start+k]};
        return v;
    endfunction

    // Parses the frame as a byte stream at standard Ethernet/ARP/IPv4 offsets
    task automatic ref_model(output bit vld, output logic [129:0] res, output bit runt);
        logic [31:0] w;
        logic [47:0] dst, smac, sha, spa, sip, dip, tpa, et, htype, ptype, op, l4a, l4b, id, seq;
        vld  = 1'b0;
        res  = '0;
        runt = (frame.size() < 11);
        if (runt) return;
        for (int i = 0; i < 42; i++) begin
            w = frame[(i + 2) / 4];
            hb[i] = w[8 * (3 - ((i + 2) % 4)) +: 8];
        end
        dst = be(0, 6);   smac = be(6, 6);   et = be(12, 2);
        htype = be(14, 2); ptype = be(16, 2); op = be(20, 2);
        sha = be(22, 6);  spa = be(28, 4);   tpa = be(38, 4);
        sip = be(26, 4);  dip = be(30, 4);
        l4a = be(34, 2);  l4b = be(36, 2);   id = be(38, 2); seq = be(40, 2);
        if (dst != BCAST && dst != SELF_MAC) return;
        if (et[15:0] == 16'h0806 && htype[15:0] == 16'h0001 && ptype[15:0] == 16'h0800 &&
            op[15:0] == 16'h0001 && tpa[31:0] == SELF_IP) begin
            vld = 1'b1;
            res = {2'd1, sha, spa[31:0], 48'h0};
        end else if (et[15:0] == 16'h0800 && hb[14] == 8'h45 && dip[31:0] == SELF_IP) begin
            if (hb[23] == 8'h01 && hb[34] == 8'h08 && hb[35] == 8'h00) begin
                vld = 1'b1;
                res = {2'd2, smac, sip[31:0], id[15:0], seq[15:0], 16'h0};
            end else if (hb[23] == 8'h11 && l4b[15:0] == 16'h5152) begin
                vld = 1'b1;
                res = {2'd3, smac, sip[31:0], 32'h0, l4a[15:0]};
            end
        end
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic s, input logic e, input bit gaps);
        int waited = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                rx_vld  = 1'b0;
                rx_sop  = 1'($urandom);
                rx_eop  = 1'($urandom);
                rx_data = $urandom;
            end
        end
        @(negedge clk);
        rx_data = d; rx_sop = s; rx_eop = e; rx_vld = 1'b1;
        while (o_rx_rdy !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (o_rx_rdy !== 1'b1) begin
            compared++; mismatched++;
            $display("[TB] FAIL beat_timeout: rdy=%b after %0d cycles, required 1", o_rx_rdy, waited);
        end
        @(posedge clk); #1;
        rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < frame.size(); i++)
            drive_beat(frame[i], i == 0, i == frame.size() - 1, gaps);
    endtask

    task automatic do_ack();
        @(negedge clk); pkt_ack = 1'b1;
        @(posedge clk); #1; pkt_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; pkt_ack = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (obs !== 130'h0) begin mismatched++; $display("[TB] FAIL reset_fields: got %h required 0", obs); end
        compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_vld: got %b required 0", o_pkt_vld); end
        compared++; if (o_rx_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_rdy: got %b required 1", o_rx_rdy); end
        compared++; if (o_drop_cnt !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_drop: got %h required 0", o_drop_cnt); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_arp();
        logic [129:0] exp = {2'd1, 48'h3CF011B2523C, 32'hC0A8012E, 48'h0};
        build_arp(BCAST, 48'h3CF011B2523C, 32'hC0A8012E, SELF_IP, 16'h0001);
        send_frame(1'b0);
        compared++; if (o_pkt_vld !== 1'b1) begin mismatched++; $display("[TB] FAIL arp_vld: got %b required 1", o_pkt_vld); end
        compared++; if (obs !== exp) begin mismatched++; $display("[TB] FAIL arp_fields: got %h required %h", obs, exp); end
        compared++; if (o_rx_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL arp_rdy_pending: got %b required 0", o_rx_rdy); end
        do_ack();
        compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL arp_ack_vld: got %b required 0", o_pkt_vld); end
        compared++; if (o_rx_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL arp_ack_rdy: got %b required 1", o_rx_rdy); end
    endtask

    task automatic test_ping();
        int rdy_low = 0;
        logic [129:0] exp = {2'd2, 48'h0C54A5312485, 32'h0A000016, 16'h1486, 16'h45C1, 16'h0000};
        build_ip(SELF_MAC, 48'h0C54A5312485, 32'h0A000016, SELF_IP, 8'h01, 32'h080082AF, 32'h148645C1, 25);
        for (int i = 0; i < frame.size(); i++) begin
            if (i >= 11 && o_rx_rdy !== 1'b1) rdy_low++;
            drive_beat(frame[i], i == 0, i == frame.size() - 1, 1'b0);
        end
        compared++; if (rdy_low != 0) begin mismatched++; $display("[TB] FAIL ping_payload_rdy: %0d stalled words, required 0", rdy_low); end
        compared++; if (o_pkt_vld !== 1'b1) begin mismatched++; $display("[TB] FAIL ping_vld: got %b required 1", o_pkt_vld); end
        compared++; if (obs !== exp) begin mismatched++; $display("[TB] FAIL ping_fields: got %h required %h", obs, exp); end
        do_ack();
    endtask

    task automatic test_udp();
        logic [129:0] exp = {2'd3, 48'h0C54A5312485, 32'h0A000016, 32'h0, 16'h1122};
        build_ip(SELF_MAC, 48'h0C54A5312485, 32'h0A000016, SELF_IP, 8'h11, 32'h11225152, 32'h00200000, 16);
        send_frame(1'b1);
        compared++; if (o_pkt_vld !== 1'b1) begin mismatched++; $display("[TB] FAIL udp_vld: got %b required 1", o_pkt_vld); end
        compared++; if (obs !== exp) begin mismatched++; $display("[TB] FAIL udp_fields: got %h required %h", obs, exp); end
        do_ack();
        build_ip(SELF_MAC, 48'h0C54A5312485, 32'h0A000016, SELF_IP, 8'h11, 32'h11225153, 32'h00200000, 16);
        send_frame(1'b0);
        compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL udp_wrong_port_vld: got %b required 0", o_pkt_vld); end
        compared++; if (o_drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL udp_wrong_port_drop: got %0d required 0", o_drop_cnt); end
        build_ip(SELF_MAC, 48'h0C54A5312485, 32'h0A000016, 32'h0A000015, 8'h11, 32'h11225152, 32'h00200000, 16);
        send_frame(1'b0);
        compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL udp_wrong_ip_vld: got %b required 0", o_pkt_vld); end
        compared++; if (o_drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL udp_wrong_ip_drop: got %0d required 0", o_drop_cnt); end
    endtask

    task automatic test_runt();
        logic [129:0] exp = {2'd1, 48'h3CF011B2523C, 32'hC0A8012E, 48'h0};
        drive_beat(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        compared++; if (o_drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL idle_beat_drop: got %0d required 0", o_drop_cnt); end
        build_arp(BCAST, 48'h3CF011B2523C, 32'hC0A8012E, SELF_IP, 16'h0001);
        frame = frame[0:5];
        send_frame(1'b0);
        compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL runt_vld: got %b required 0", o_pkt_vld); end
        compared++; if (o_drop_cnt !== 16'd1) begin mismatched++; $display("[TB] FAIL runt_drop: got %0d required 1", o_drop_cnt); end
        build_ip(SELF_MAC, 48'h0C54A5312485, 32'h0A000016, SELF_IP, 8'h01, 32'h080082AF, 32'h148645C1, 25);
        for (int i = 0; i < 7; i++) drive_beat(frame[i], i == 0, 1'b0, 1'b0);
        build_arp(BCAST, 48'h3CF011B2523C, 32'hC0A8012E, SELF_IP, 16'h0001);
        send_frame(1'b0);
        compared++; if (o_drop_cnt !== 16'd2) begin mismatched++; $display("[TB] FAIL abort_drop: got %0d required 2", o_drop_cnt); end
        compared++; if (o_pkt_vld !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_arp_vld: got %b required 1", o_pkt_vld); end
        compared++; if (obs !== exp) begin mismatched++; $display("[TB] FAIL abort_arp_fields: got %h required %h", obs, exp); end
        do_ack();
        drive_beat(32'h0000FFFF, 1'b1, 1'b1, 1'b0);
        compared++; if (o_drop_cnt !== 16'd3) begin mismatched++; $display("[TB] FAIL sop_eop_drop: got %0d required 3", o_drop_cnt); end
        compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL sop_eop_vld: got %b required 0", o_pkt_vld); end
    endtask

    task automatic test_backpressure();
        logic [129:0] held = {2'd2, 48'h0C54A5312485, 32'h0A000016, 16'h1486, 16'h45C1, 16'h0000};
        logic [129:0] exp  = {2'd1, 48'h3CF011B2523C, 32'hC0A8012E, 48'h0};
        build_ip(SELF_MAC, 48'h0C54A5312485, 32'h0A000016, SELF_IP, 8'h01, 32'h080082AF, 32'h148645C1, 25);
        send_frame(1'b0);
        build_arp(BCAST, 48'h3CF011B2523C, 32'hC0A8012E, SELF_IP, 16'h0001);
        @(negedge clk);
        rx_data = frame[0]; rx_sop = 1'b1; rx_eop = 1'b0; rx_vld = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            compared++; if (o_rx_rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_rdy cycle %0d: got %b required 0", c, o_rx_rdy); end
            compared++; if (obs !== held || o_pkt_vld !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold cycle %0d: got %h vld %b required %h vld 1", c, obs, o_pkt_vld, held); end
        end
        @(negedge clk); pkt_ack = 1'b1;
        @(posedge clk); #1;
        pkt_ack = 1'b0; rx_vld = 1'b0; rx_sop = 1'b0;
        compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ack_vld: got %b required 0", o_pkt_vld); end
        compared++; if (o_rx_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ack_rdy: got %b required 1", o_rx_rdy); end
        send_frame(1'b0);
        compared++; if (o_pkt_vld !== 1'b1 || obs !== exp) begin mismatched++; $display("[TB] FAIL bp_arp_result: got %h vld %b required %h vld 1", obs, o_pkt_vld, exp); end
        do_ack();
    endtask

    task automatic test_reset_mid();
        logic [129:0] exp = {2'd3, 48'h0C54A5312485, 32'h0A000016, 32'h0, 16'h1122};
        build_arp(BCAST, 48'h3CF011B2523C, 32'hC0A8012E, SELF_IP, 16'h0001);
        for (int i = 0; i < 6; i++) drive_beat(frame[i], i == 0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        compared++; if (obs !== 130'h0 || o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_fields: got %h vld %b required 0", obs, o_pkt_vld); end
        compared++; if (o_drop_cnt !== 16'd0) begin mismatched++; $display("[TB] FAIL midreset_drop: got %0d required 0", o_drop_cnt); end
        compared++; if (o_rx_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_rdy: got %b required 1", o_rx_rdy); end
        @(negedge clk); rst_n = 1'b1;
        build_ip(BCAST, 48'h0C54A5312485, 32'h0A000016, SELF_IP, 8'h11, 32'h11225152, 32'h0, 12);
        send_frame(1'b0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        compared++; if (o_pkt_vld !== 1'b0 || o_rx_rdy !== 1'b1) begin mismatched++; $display("[TB] FAIL result_reset: got vld %b rdy %b required vld 0 rdy 1", o_pkt_vld, o_rx_rdy); end
        @(negedge clk); rst_n = 1'b1;
        send_frame(1'b0);
        compared++; if (o_pkt_vld !== 1'b1 || obs !== exp) begin mismatched++; $display("[TB] FAIL post_reset_result: got %h vld %b required %h vld 1", obs, o_pkt_vld, exp); end
        do_ack();
    endtask

    task automatic test_random();
        int exp_drop = 0;
        int kind, mut, len;
        bit ev, er;
        logic [129:0] eo;
        logic [47:0] dst, smac;
        logic [31:0] sip, tip;
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 2);
            mut  = $urandom_range(0, 6);
            dst  = ($urandom_range(0, 1) == 1) ? BCAST : SELF_MAC;
            if (mut == 1) dst = {8'h02, 8'($urandom), 32'($urandom)};
            tip  = (mut == 2) ? (SELF_IP ^ 32'h1) : SELF_IP;
            smac = {16'($urandom), 32'($urandom)};
            sip  = $urandom;
            case (kind)
                0: build_arp(dst, smac, sip, tip, (mut == 3) ? 16'h0002 : 16'h0001);
                1: build_ip(dst, smac, sip, tip, (mut == 3) ? 8'h06 : 8'h01,
                            {((mut == 5) ? 16'h0000 : 16'h0800), 16'($urandom)}, $urandom, $urandom_range(11, 20));
                default: build_ip(dst, smac, sip, tip, (mut == 3) ? 8'h01 : 8'h11,
                            {16'($urandom), ((mut == 5) ? 16'h5153 : 16'h5152)}, $urandom, $urandom_range(11, 20));
            endcase
            if (mut == 4) begin
                len = $urandom_range(1, 10);
                frame = frame[0:len-1];
            end
            if ($urandom_range(0, 3) == 0) drive_beat($urandom, 1'b0, 1'($urandom), 1'b0);
            ref_model(ev, eo, er);
            if (er) exp_drop++;
            send_frame(1'b1);
            compared++; if (o_pkt_vld !== ev) begin mismatched++; $display("[TB] FAIL rand%0d_vld: got %b required %b", n, o_pkt_vld, ev); end
            if (ev) begin
                compared++; if (obs !== eo) begin mismatched++; $display("[TB] FAIL rand%0d_fields: got %h required %h", n, obs, eo); end
            end
            compared++; if (o_drop_cnt !== 16'(exp_drop)) begin mismatched++; $display("[TB] FAIL rand%0d_drop: got %0d required %0d", n, o_drop_cnt, exp_drop); end
            if (o_pkt_vld === 1'b1) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                do_ack();
                compared++; if (o_pkt_vld !== 1'b0) begin mismatched++; $display("[TB] FAIL rand%0d_ack: got %b required 0", n, o_pkt_vld); end
            end
        end
    endtask

    initial begin
        self_mac = SELF_MAC;
        self_ip  = SELF_IP;
        test_reset();
        test_arp();
        test_ping();
        test_udp();
        test_runt();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
